// File: rtl/carry_look_ahead_16bit.sv
// carry_look_ahead_16bit: registered 16-bit two-level carry-lookahead adder (4x 4-bit CLA + lookahead unit)
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       pg,
   output logic       gg
);
   logic [3:0] p, g, c;
   // bit-level propagate/generate with in-group carries flattened to sum-of-products
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      s    = p ^ c;
      pg   = &p;
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end
endmodule

module carry_look_ahead_16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [3:0]  pg, gg;
   logic [4:0]  gc;
   logic [15:0] sum_d, sum_q;
   logic        cout_q;
   for (genvar k = 0; k < 4; k++) begin : g_grp
      cla4 u_cla (
         .a   (a[4*k+3:4*k]),
         .b   (b[4*k+3:4*k]),
         .cin (gc[k]),
         .s   (sum_d[4*k+3:4*k]),
         .pg  (pg[k]),
         .gg  (gg[k])
      );
   end
   // second-level lookahead: every group carry comes straight from cin and group P/G
   always_comb begin
      gc[0] = cin;
      gc[1] = gg[0] | (pg[0] & cin);
      gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
      gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
      gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
            | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
   end
   // output register; reset wins over the add and drops the sampled operation
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= 16'h0000;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= gc[4];
      end
   end
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_carry_look_ahead_16bit.sv
// tb_carry_look_ahead_16bit: directed and random checks of the registered 16-bit CLA adder
module tb_carry_look_ahead_16bit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic [15:0] sum;
   logic        cout;
   int          n_checks = 0;
   int          n_errors = 0;

   carry_look_ahead_16bit dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   // present inputs, then clock once and settle past the edge
   task automatic step(input logic r, input logic [15:0] va, input logic [15:0] vb, input logic vc);
      rst = r;
      a   = va;
      b   = vb;
      cin = vc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      n_checks++;
      if ({cout, sum} !== 17'h0_0000) begin
         n_errors++;
         $display("FAIL reset: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
      end
      step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
      n_checks++;
      if ({cout, sum} !== 17'h1_FFFF) begin
         n_errors++;
         $display("FAIL reset_release: got cout=%b sum=%h, want cout=1 sum=ffff", cout, sum);
      end
   endtask

   task automatic test_basic();
      logic [15:0] va [4] = '{16'd0, 16'd14, 16'd5, 16'd999};
      logic [15:0] vb [4] = '{16'd0, 16'd1, 16'd0, 16'd0};
      logic        vc [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [16:0] ex [4] = '{17'd1, 17'd16, 17'd5, 17'd1000};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, va[i], vb[i], vc[i]);
         n_checks++;
         if ({cout, sum} !== ex[i]) begin
            n_errors++;
            $display("FAIL basic[%0d]: got %h, want %h", i, {cout, sum}, ex[i]);
         end
      end
   endtask

   task automatic test_full_carry();
      step(1'b0, 16'hFFFF, 16'h0000, 1'b1);
      n_checks++;
      if ({cout, sum} !== 17'h1_0000) begin
         n_errors++;
         $display("FAIL full_carry: got %h, want 10000", {cout, sum});
      end
   endtask

   task automatic test_boundaries();
      logic [15:0] va [5] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'h8000, 16'h7FFF};
      logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0000};
      logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [16:0] ex [5] = '{17'h0_0010, 17'h0_0100, 17'h0_1000, 17'h1_0000, 17'h0_8000};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, va[i], vb[i], vc[i]);
         n_checks++;
         if ({cout, sum} !== ex[i]) begin
            n_errors++;
            $display("FAIL boundary[%0d]: got %h, want %h", i, {cout, sum}, ex[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va, vb;
      logic        vc;
      logic [16:0] ex;
      int          errs = 0;
      for (int i = 0; i < 10000; i++) begin
         va = 16'($urandom);
         vb = 16'($urandom);
         vc = 1'($urandom);
         ex = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
         step(1'b0, va, vb, vc);
         n_checks++;
         if ({cout, sum} !== ex) begin
            n_errors++;
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d]: a=%h b=%h cin=%b got %h, want %h", i, va, vb, vc, {cout, sum}, ex);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] va, vb;
      logic        vc;
      logic [16:0] ex;
      va = 16'($urandom);
      vb = 16'($urandom);
      vc = 1'($urandom);
      ex = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
      step(1'b0, va, vb, vc);
      n_checks++;
      if ({cout, sum} !== ex) begin
         n_errors++;
         $display("FAIL mid_pre: got %h, want %h", {cout, sum}, ex);
      end
      step(1'b1, 16'hFFFF, 16'h0001, 1'b1);
      n_checks++;
      if ({cout, sum} !== 17'h0_0000) begin
         n_errors++;
         $display("FAIL mid_reset: got %h, want 00000", {cout, sum});
      end
      va = 16'($urandom);
      vb = 16'($urandom);
      vc = 1'($urandom);
      ex = {1'b0, va} + {1'b0, vb} + {16'b0, vc};
      step(1'b0, va, vb, vc);
      n_checks++;
      if ({cout, sum} !== ex) begin
         n_errors++;
         $display("FAIL mid_post: got %h, want %h", {cout, sum}, ex);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_carry();
      test_boundaries();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
